rank_sched: RTL and testbench

RANK_SCHED -- requirements
Module: rank_sched

---
 rtl/rank_sched.sv | 113 +++++++++++
 tb/tb_rank_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_sched.sv
// PageRank run scheduler: sequences num_iter PE iterations, then one top-10 sort.
// Latency: 3 cycles per iteration plus 2 for the sort; the wait states are bounded by a TIMEOUT-cycle watchdog.
// Backpressure: iter_go and sort_go are single-cycle launches, and abort cancels the run on the next edge.
module rank_sched #(
    parameter int N       = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [7:0]   num_iter,
    input  logic [N-1:0] pe_done,
    input  logic         sort_done,
    output logic         iter_go,
    output logic         sort_go,
    output logic [7:0]   iter_count,
    output logic         busy,
    output logic         result_valid,
    output logic         error
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_PE,
        SORT,
        WAIT_SORT,
        ERR
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  num_lat;
    logic [15:0] wait_cnt;
    logic        accept;
    logic        pe_cmpl;
    logic        sort_cmpl;
    logic        timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // wait_cnt == 0 marks the guard cycle, so a done level left over from the last iteration is skipped
    always_comb begin
        accept    = (state == IDLE || state == ERR) && start && !abort;
        pe_cmpl   = (state == WAIT_PE) && (wait_cnt != 16'd0) && (&pe_done);
        sort_cmpl = (state == WAIT_SORT) && sort_done;
        timed_out = (wait_cnt == WAIT_LIMIT);
        iter_go   = (state == LAUNCH);
        sort_go   = (state == SORT);
        busy      = (state != IDLE) && (state != ERR);
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ERR: if (start) state_nxt = LAUNCH;
                LAUNCH:    state_nxt = WAIT_PE;
                WAIT_PE: begin
                    if (pe_cmpl) begin
                        state_nxt = (iter_count + 8'd1 < num_lat) ? LAUNCH : SORT;
                    end else if (timed_out) begin
                        state_nxt = ERR;
                    end
                end
                SORT:      state_nxt = WAIT_SORT;
                WAIT_SORT: begin
                    if (sort_cmpl) begin
                        state_nxt = IDLE;
                    end else if (timed_out) begin
                        state_nxt = ERR;
                    end
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_lat      <= 8'd0;
            iter_count   <= 8'd0;
            wait_cnt     <= 16'd0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Only LAUNCH and SORT lead into the wait states, so this clears on every entry
            wait_cnt <= (state == WAIT_PE || state == WAIT_SORT) ? wait_cnt + 16'd1 : 16'd0;
            if (accept) begin
                num_lat      <= (num_iter == 8'd0) ? 8'd1 : num_iter;
                iter_count   <= 8'd0;
                result_valid <= 1'b0;
                error        <= 1'b0;
            end
            if (abort) begin
                result_valid <= 1'b0;
                if (state == ERR) error <= 1'b0;
            end else begin
                if (pe_cmpl) iter_count <= iter_count + 8'd1;
                if (sort_cmpl) result_valid <= 1'b1;
                if (state_nxt == ERR && state != ERR) error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rank_sched.sv
// Directed bench for rank_sched: normal run, zero iterations, stale done, timeout, abort, async reset.
module tb_rank_sched;

    localparam int N       = 8;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [7:0]   num_iter;
    logic [N-1:0] pe_done;
    logic         sort_done;
    logic         iter_go;
    logic         sort_go;
    logic [7:0]   iter_count;
    logic         busy;
    logic         result_valid;
    logic         error;

    int vectors     = 0;
    int miscompares = 0;
    int n_ig        = 0;
    int n_sg        = 0;
    int ig0;
    int sg0;

    rank_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_iter     (num_iter),
        .pe_done      (pe_done),
        .sort_done    (sort_done),
        .iter_go      (iter_go),
        .sort_go      (sort_go),
        .iter_count   (iter_count),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (iter_go) n_ig++;
        if (sort_go) n_sg++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        num_iter  = 8'd0;
        pe_done   = '0;
        sort_done = 1'b0;
        repeat (2) tick();
        check("rst_iter_go", 32'(iter_go), 32'd0);
        check("rst_sort_go", 32'(sort_go), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_iter_count", 32'(iter_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Normal run: three iterations, done 5 cycles after each launch, sort_done 2 cycles after sort_go
        ig0 = n_ig;
        sg0 = n_sg;
        num_iter = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_launch_go", 32'(iter_go), 32'd1);
        check("t1_launch_busy", 32'(busy), 32'd1);
        check("t1_launch_count", 32'(iter_count), 32'd0);
        for (int it = 0; it < 3; it++) begin
            repeat (5) tick();
            pe_done = '1;
            tick();
            pe_done = '0;
            check("t1_iter_count", 32'(iter_count), 32'(it + 1));
            if (it < 2) check("t1_relaunch", 32'(iter_go), 32'd1);
            else        check("t1_sort_go", 32'(sort_go), 32'd1);
        end
        tick();
        tick();
        sort_done = 1'b1;
        tick();
        sort_done = 1'b0;
        check("t1_result_valid", 32'(result_valid), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_final_count", 32'(iter_count), 32'd3);
        check("t1_n_iter_go", 32'(n_ig - ig0), 32'd3);
        check("t1_n_sort_go", 32'(n_sg - sg0), 32'd1);

        // Zero iterations at minimum latency: result_valid 5 edges after the start edge
        ig0 = n_ig;
        sg0 = n_sg;
        pe_done = '1;
        sort_done = 1'b1;
        num_iter = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_rv_cleared", 32'(result_valid), 32'd0);
        check("t2_launch_go", 32'(iter_go), 32'd1);
        repeat (4) tick();
        check("t2_rv_early", 32'(result_valid), 32'd0);
        check("t2_busy_wait_sort", 32'(busy), 32'd1);
        tick();
        check("t2_rv", 32'(result_valid), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_count", 32'(iter_count), 32'd1);
        check("t2_n_iter_go", 32'(n_ig - ig0), 32'd1);
        check("t2_n_sort_go", 32'(n_sg - sg0), 32'd1);
        pe_done = '0;
        sort_done = 1'b0;

        // Stale done held through LAUNCH and the guard cycle must not count
        num_iter = 8'd1;
        pe_done = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pe_done = '0;
        check("t3_guard_count", 32'(iter_count), 32'd0);
        check("t3_guard_busy", 32'(busy), 32'd1);
        check("t3_guard_sort_go", 32'(sort_go), 32'd0);
        repeat (3) tick();
        check("t3_hold_count", 32'(iter_count), 32'd0);
        check("t3_hold_sort_go", 32'(sort_go), 32'd0);
        check("t3_hold_iter_go", 32'(iter_go), 32'd0);
        pe_done = '1;
        tick();
        pe_done = '0;
        check("t3_sort_go", 32'(sort_go), 32'd1);
        check("t3_count", 32'(iter_count), 32'd1);
        tick();
        sort_done = 1'b1;
        tick();
        sort_done = 1'b0;
        check("t3_rv", 32'(result_valid), 32'd1);

        // Watchdog: bit 5 stuck low, ERR after 16 WAIT_PE cycles
        num_iter = 8'd2;
        pe_done = 8'hDF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("t4_busy_before", 32'(busy), 32'd1);
        check("t4_error_before", 32'(error), 32'd0);
        tick();
        check("t4_error", 32'(error), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_count", 32'(iter_count), 32'd0);
        check("t4_rv", 32'(result_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_restart_error", 32'(error), 32'd0);
        check("t4_restart_go", 32'(iter_go), 32'd1);
        repeat (17) tick();
        check("t4_error_again", 32'(error), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t4_abort_error", 32'(error), 32'd0);
        check("t4_abort_iter_go", 32'(iter_go), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        pe_done = '0;

        // Abort in the third WAIT_PE cycle of iteration 2
        ig0 = n_ig;
        sg0 = n_sg;
        num_iter = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pe_done = '1;
        tick();
        tick();
        pe_done = '0;
        check("t5_count1", 32'(iter_count), 32'd1);
        check("t5_relaunch", 32'(iter_go), 32'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(iter_count), 32'd1);
        check("t5_rv", 32'(result_valid), 32'd0);
        check("t5_iter_go", 32'(iter_go), 32'd0);
        repeat (3) tick();
        check("t5_n_sort_go", 32'(n_sg - sg0), 32'd0);
        check("t5_n_iter_go", 32'(n_ig - ig0), 32'd2);

        // Asynchronous reset in WAIT_SORT, late sort_done ignored
        num_iter = 8'd1;
        pe_done = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t6_wait_sort_busy", 32'(busy), 32'd1);
        check("t6_wait_sort_count", 32'(iter_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_count", 32'(iter_count), 32'd0);
        check("t6_rst_rv", 32'(result_valid), 32'd0);
        check("t6_rst_error", 32'(error), 32'd0);
        check("t6_rst_iter_go", 32'(iter_go), 32'd0);
        check("t6_rst_sort_go", 32'(sort_go), 32'd0);
        ig0 = n_ig;
        sg0 = n_sg;
        #2;
        reset = 1'b0;
        sort_done = 1'b1;
        repeat (3) tick();
        check("t6_post_rv", 32'(result_valid), 32'd0);
        check("t6_post_busy", 32'(busy), 32'd0);
        check("t6_post_iter_go", 32'(n_ig - ig0), 32'd0);
        check("t6_post_sort_go", 32'(n_sg - sg0), 32'd0);
        sort_done = 1'b0;
        pe_done = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
